serial_tx_sequencer: RTL and testbench

Sequencer that sits around the team's parallel-load shift register (Register_With_Load chain) and turns it into a framed asynchronous serial transmitter. Upstream side: accepts a word over a valid/ready handshake and loads it into the shift register. Downstream side: issues timed Shift pulses, consumes the register's serial output, and frames it MSB-first with start/stop bits on Tx. Feeds the board-level TX pin.

---
 rtl/serial_tx_pkg.sv | 22 ++
 rtl/serial_tx_baud_tick_gen.sv | 32 +++
 rtl/serial_tx_sequencer.sv | 137 +++++++++++++
 tb/tb_serial_tx_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the framed serial transmitter.
// Optional parity: define SERIAL_TX_PARITY_EN.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  localparam int STOP_CNT_W = 1;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_tx_baud_tick_gen.sv
// Bit-period timer: one-cycle tick every BAUD_DIV clocks.
// Restarted from zero by clear so a frame's bit grid aligns to accept.
module baud_tick_gen
  import serial_tx_pkg::*;
#(
  parameter int BAUD_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int BAUD_W = cnt_w(BAUD_DIV);
  localparam logic [BAUD_W-1:0] LAST =
    BAUD_W'(BAUD_DIV - 1);

  logic [BAUD_W-1:0] baud_cnt;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      baud_cnt <= '0;
    end else if (baud_cnt == LAST) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  assign tick = (baud_cnt == LAST);

endmodule

// File: rtl/serial_tx_sequencer.sv
// Framed MSB-first serial transmitter around a parallel-load shift register.
// Optional even parity bit: define SERIAL_TX_PARITY_EN.
module serial_tx_sequencer
  import serial_tx_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int BAUD_DIV    = 16,
  parameter int STOP_BITS   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_LENGTH-1:0] Data_In,
  input  logic                   Data_Valid,
  output logic                   Data_Ready,
  output logic                   SR_Load,
  output logic                   SR_Shift,
  output logic                   SR_Sync_Reset,
  output logic [WORD_LENGTH-1:0] SR_Parallel_In,
  output logic                   SR_Serial_In,
  input  logic                   SR_Serial_Out,
  output logic                   Tx,
  output logic                   Busy,
  output logic                   Done
);

  localparam int BIT_W = cnt_w(WORD_LENGTH + 1);
  localparam logic [BIT_W-1:0] LAST_BIT =
    BIT_W'(WORD_LENGTH - 1);
  localparam logic [STOP_CNT_W-1:0] LAST_STOP =
    STOP_CNT_W'(STOP_BITS - 1);

  state_t                  state;
  logic [BIT_W-1:0]        bit_cnt;
  logic [STOP_CNT_W-1:0]   stop_cnt;
  logic                    tick;
  logic                    accept;
  logic                    last_stop;
  logic                    tx_level;
  logic                    parity_bit;

  baud_tick_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(accept),
    .tick (tick)
  );

  // Every strobe is gated by reset so outputs go quiet in the reset cycle.
  assign Data_Ready     = reset & (state == IDLE);
  assign accept         = Data_Valid & Data_Ready;
  assign SR_Load        = accept;
  assign SR_Shift       = reset & (state == DATA) & tick;
  assign last_stop      = (state == STOP) & tick &
                          (stop_cnt == LAST_STOP);
  assign Done           = reset & last_stop;
  assign SR_Sync_Reset  = ~reset | last_stop;
  assign Busy           = reset & (state != IDLE);
  assign SR_Parallel_In = Data_In;
  assign SR_Serial_In   = 1'b0;
  assign Tx             = ~reset | tx_level;

`ifdef SERIAL_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      parity_bit <= 1'b0;
    end else if (accept) begin
      parity_bit <= ^Data_In;
    end
  end
`else
  assign parity_bit = IDLE_LEVEL;
`endif

  always_comb begin
    tx_level = IDLE_LEVEL;
    unique case (state)
      IDLE:    tx_level = IDLE_LEVEL;
      START:   tx_level = START_LEVEL;
      DATA:    tx_level = SR_Serial_Out;
      PARITY:  tx_level = parity_bit;
      STOP:    tx_level = IDLE_LEVEL;
      default: tx_level = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      stop_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state    <= START;
            bit_cnt  <= '0;
            stop_cnt <= '0;
          end
        end
        START: begin
          if (tick) state <= DATA;
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) state <= STOP;
        end
        STOP: begin
          if (tick) begin
            if (stop_cnt == LAST_STOP) begin
              stop_cnt <= '0;
              state    <= IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_sequencer.sv
// Bench for serial_tx_sequencer: one- and two-stop-bit instances, each
// driving a behavioural shift register, checked against a frame-offset model.
module tb_serial_tx_sequencer;

  localparam int W = 8;
  localparam int B = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int L0 = (1 + W + P + 1) * B;
  localparam int L1 = (1 + W + P + 2) * B;

  logic         clk = 1'b0;
  logic         reset;
  logic         dv;
  logic [W-1:0] din;

  logic         ready [2];
  logic         load  [2];
  logic         shift [2];
  logic         srst  [2];
  logic [W-1:0] pin   [2];
  logic         sin   [2];
  logic         sout  [2];
  logic         tx    [2];
  logic         busy  [2];
  logic         done  [2];

  logic [W-1:0] q0, q1;

  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  bit  started = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_tx_sequencer #(
    .WORD_LENGTH(W), .BAUD_DIV(B), .STOP_BITS(1)
  ) dut (
    .clk(clk), .reset(reset),
    .Data_In(din), .Data_Valid(dv), .Data_Ready(ready[0]),
    .SR_Load(load[0]), .SR_Shift(shift[0]),
    .SR_Sync_Reset(srst[0]), .SR_Parallel_In(pin[0]),
    .SR_Serial_In(sin[0]), .SR_Serial_Out(sout[0]),
    .Tx(tx[0]), .Busy(busy[0]), .Done(done[0])
  );

  serial_tx_sequencer #(
    .WORD_LENGTH(W), .BAUD_DIV(B), .STOP_BITS(2)
  ) dut2 (
    .clk(clk), .reset(reset),
    .Data_In(din), .Data_Valid(dv), .Data_Ready(ready[1]),
    .SR_Load(load[1]), .SR_Shift(shift[1]),
    .SR_Sync_Reset(srst[1]), .SR_Parallel_In(pin[1]),
    .SR_Serial_In(sin[1]), .SR_Serial_Out(sout[1]),
    .Tx(tx[1]), .Busy(busy[1]), .Done(done[1])
  );

  // Register_With_Load: sync clear, then load, then shift toward MSB.
  always @(posedge clk) begin
    if (srst[0]) q0 <= '0;
    else if (load[0]) q0 <= pin[0];
    else if (shift[0]) q0 <= {q0[W-2:0], sin[0]};
  end
  always @(posedge clk) begin
    if (srst[1]) q1 <= '0;
    else if (load[1]) q1 <= pin[1];
    else if (shift[1]) q1 <= {q1[W-2:0], sin[1]};
  end
  assign sout[0] = q0[W-1];
  assign sout[1] = q1[W-1];

  task automatic chk(input string nm, input int idx,
                     input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d] cyc=%0d got=%h want=%h",
               nm, idx, cyc, act, exp);
    end
  endtask

  // Model: per instance, offset t from the accept cycle decides every output.
  bit           active [2];
  int           t      [2];
  logic [W-1:0] w      [2];
  logic         par    [2];

  always @(negedge clk) begin
    int L, idx;
    logic e_tx, e_sh, e_dn, e_rd, e_bz, e_ld, e_sr;
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        L = (i == 0) ? L0 : L1;
        e_tx = 1'b1; e_sh = 1'b0; e_dn = 1'b0;
        e_rd = 1'b0; e_bz = 1'b0; e_ld = 1'b0; e_sr = 1'b0;
        if (!reset) begin
          e_sr = 1'b1;
          active[i] = 1'b0;
        end else if (!active[i]) begin
          e_rd = 1'b1;
          e_ld = dv;
          if (dv) begin
            active[i] = 1'b1;
            t[i] = 0;
            w[i] = din;
            par[i] = ^din;
          end
        end else begin
          t[i] = t[i] + 1;
          e_bz = 1'b1;
          if (t[i] <= B) begin
            e_tx = 1'b0;
          end else if (t[i] <= B + W * B) begin
            idx = (t[i] - B - 1) / B;
            e_tx = w[i][W-1-idx];
            e_sh = ((t[i] - B) % B) == 0;
          end else if (P == 1 && t[i] <= B + (W + 1) * B) begin
            e_tx = par[i];
          end
          e_dn = (t[i] == L);
          e_sr = e_dn;
          if (t[i] == L) active[i] = 1'b0;
        end
        chk("tx", i, 8'(tx[i]), 8'(e_tx));
        chk("shift", i, 8'(shift[i]), 8'(e_sh));
        chk("done", i, 8'(done[i]), 8'(e_dn));
        chk("ready", i, 8'(ready[i]), 8'(e_rd));
        chk("busy", i, 8'(busy[i]), 8'(e_bz));
        chk("load", i, 8'(load[i]), 8'(e_ld));
        chk("sync_reset", i, 8'(srst[i]), 8'(e_sr));
        chk("serial_in", i, 8'(sin[i]), 8'h00);
        if (load[i]) chk("par_in", i, pin[i], din);
      end
    end
  end

  task automatic at(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, output int k);
    @(posedge clk);
    #1 dv = 1'b1; din = d;
    @(negedge clk);
    k = cyc;
    @(posedge clk);
    #1 dv = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy[0] || busy[1]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 0, 8'(n < 300), 8'h01);
  endtask

  initial begin
    int k;
    logic [7:0] b;
    reset = 1'b0; dv = 1'b0; din = '0;
    @(posedge clk);
    started = 1'b1;
    @(negedge clk);
    chk("rst_tx", 0, 8'(tx[0]), 8'h01);
    chk("rst_srst", 0, 8'(srst[0]), 8'h01);
    chk("rst_ready", 0, 8'(ready[0]), 8'h00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Single word 0xA5
    send(8'hA5, k);
    for (int i = 0; i < 8; i++) begin
      at(k + 6 + 4 * i);
      b[7-i] = tx[0];
    end
    chk("a5_bits", 0, b, 8'hA5);
    at(k + 36); chk("a5_shift36", 0, 8'(shift[0]), 8'h01);
    at(k + L0 - 1); chk("a5_done_early", 0, 8'(done[0]), 8'h00);
    at(k + L0);
    chk("a5_done", 0, 8'(done[0]), 8'h01);
    chk("a5_srst", 0, 8'(srst[0]), 8'h01);
    at(k + L0 + 1); chk("a5_ready", 0, 8'(ready[0]), 8'h01);
    wait_idle();

    // Back-to-back 0xFF then 0x00 with Data_Valid held
    @(posedge clk);
    #1 dv = 1'b1; din = 8'hFF;
    @(negedge clk);
    k = cyc;
    @(posedge clk);
    #1 din = 8'h00;
    at(k + L0); chk("b2b_stop", 0, 8'(tx[0]), 8'h01);
    at(k + L0 + 1);
    chk("b2b_load", 0, 8'(load[0]), 8'h01);
    chk("b2b_gap", 0, 8'(tx[0]), 8'h01);
    at(k + L0 + 2); chk("b2b_start", 0, 8'(tx[0]), 8'h00);
    @(posedge clk);
    #1 dv = 1'b0;
    wait_idle();

    // Reset mid-DATA
    send(8'h5A, k);
    at(k + 14);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_tx", 0, 8'(tx[0]), 8'h01);
    chk("abort_busy", 0, 8'(busy[0]), 8'h00);
    chk("abort_srst", 0, 8'(srst[0]), 8'h01);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_ready", 0, 8'(ready[0]), 8'h01);
    wait_idle();

    // Data_Valid toggling mid-frame with 0x3C
    send(8'h3C, k);
    fork
      begin
        repeat (28) begin
          @(posedge clk);
          #1 dv = ~dv; din = 8'($urandom);
        end
        dv = 1'b0;
      end
      begin
        for (int i = 0; i < 8; i++) begin
          at(k + 6 + 4 * i);
          b[7-i] = tx[0];
        end
      end
    join
    chk("3c_bits", 0, b, 8'h3C);
    wait_idle();

    // 0x07: parity bit 1 (when enabled) then stop
    send(8'h07, k);
    at(k + 38); chk("07_post_data", 0, 8'(tx[0]), 8'h01);
    at(k + L0); chk("07_done", 0, 8'(done[0]), 8'h01);
    wait_idle();

    // 0x81 on the two-stop-bit instance
    send(8'h81, k);
    for (int c = k + 37 + 4 * P; c <= k + L1; c++) begin
      at(c);
      chk("81_stop_hi", 1, 8'(tx[1]), 8'h01);
    end
    chk("81_done", 1, 8'(done[1]), 8'h01);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
